// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and counter widths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_t;

    localparam int BURST_CNT_W = 4;
    localparam int ACK_CNT_W   = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after start, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int cand;

    // Scan from the farthest offset back towards start so the nearest request is the last write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(start) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                idx   = W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte producers onto a single UART transmitter using
// round-robin selection with optional per-requester bursts.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 1,
    parameter int ACK_TO    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_rdy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    ack_err
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t             state;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [ACK_CNT_W-1:0]   ack_timer;
    logic [IDW-1:0]         rr_start;
    logic [IDW-1:0]         rr_idx;
    logic [IDW-1:0]         winner;
    logic                   rr_found;
    logic                   burst_hit;
    logic                   grant;

    assign rr_start = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    uart_rr_pick #(
        .N (NREQ),
        .W (IDW)
    ) u_pick (
        .req   (req_vld),
        .start (rr_start),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // A zero burst count means no burst is open (after reset or an ack timeout).
    assign burst_hit = (burst_cnt != '0) && (int'(burst_cnt) < MAX_BURST) && req_vld[grant_id];
    assign winner    = burst_hit ? grant_id : rr_idx;
    assign grant     = !rst && (state == IDLE) && !tx_busy && (burst_hit || rr_found);

    always_comb begin
        req_rdy = '0;
        if (grant) begin
            req_rdy[winner] = 1'b1;
        end
    end

    // With MAX_BURST=16 the 4-bit count wraps to zero after the 16th byte, which closes the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            ack_err   <= 1'b0;
            tx_data   <= '0;
            burst_cnt <= '0;
            ack_timer <= '0;
            grant_id  <= IDW'(NREQ - 1);
        end else begin
            tx_start <= 1'b0;
            ack_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        tx_data   <= req_data[int'(winner) * 8 +: 8];
                        grant_id  <= winner;
                        burst_cnt <= burst_hit ? burst_cnt + BURST_CNT_W'(1) : BURST_CNT_W'(1);
                        tx_start  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    ack_timer <= ACK_CNT_W'(1);
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_timer == ACK_CNT_W'(ACK_TO - 1)) begin
                        ack_err   <= 1'b1;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        ack_timer <= ack_timer + ACK_CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: transaction-level arbiter model checked every cycle,
// directed scenarios pinned with literal grant/byte sequences, then random traffic.
module tb_uart_tx_arb;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 2;
    localparam int ACK_TO    = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_rdy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              ack_err;

    int total;
    int bad;
    int cycle;
    int tx_mode;
    int frame_len;
    int req_mode;
    logic [NREQ-1:0] vld_mask;
    int   rem  [NREQ];
    int   seq  [NREQ];
    logic [7:0] base [NREQ];
    int dut_grants[$];
    int dut_bytes[$];
    int start_cycles[$];
    int err_cycles[$];
    int rdy_seen;
    int start_seen;

    // Model: m_t counts cycles since the grant (-1 = free to grant), m_run = bytes in the open burst.
    int       m_t;
    bit       m_acked;
    int       m_gid;
    int       m_run;
    logic [7:0] m_data;
    bit       m_err_next;

    uart_tx_arb #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .ACK_TO    (ACK_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .ack_err  (ack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic void modelReset();
        m_t        = -1;
        m_acked    = 1'b0;
        m_gid      = NREQ - 1;
        m_run      = 0;
        m_data     = 8'h00;
        m_err_next = 1'b0;
    endfunction

    function automatic int modelPick(input logic [NREQ-1:0] vld);
        if (m_run > 0 && m_run < MAX_BURST && vld[m_gid]) return m_gid;
        for (int j = 1; j <= NREQ; j++) begin
            if (vld[(m_gid + j) % NREQ]) return (m_gid + j) % NREQ;
        end
        return -1;
    endfunction

    // Compare process: expectations for this cycle, then advance the model across the coming edge.
    initial begin
        int win;
        logic [NREQ-1:0] exp_rdy;
        cycle = 0;
        modelReset();
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                modelReset();
                continue;
            end
            win = -1;
            if (m_t < 0 && !tx_busy) win = modelPick(req_vld);
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            checkOutput("req_rdy", 32'(req_rdy), 32'(exp_rdy));
            checkOutput("tx_start", 32'(tx_start), 32'(m_t == 1));
            checkOutput("ack_err", 32'(ack_err), 32'(m_err_next));
            checkOutput("tx_data", 32'(tx_data), 32'(m_data));
            checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
            for (int i = 0; i < NREQ; i++) begin
                if (req_rdy[i]) begin
                    dut_grants.push_back(i);
                    rdy_seen++;
                end
            end
            if (tx_start) begin
                dut_bytes.push_back(int'(tx_data));
                start_cycles.push_back(cycle);
                start_seen++;
            end
            if (ack_err) err_cycles.push_back(cycle);

            m_err_next = 1'b0;
            if (win >= 0) begin
                if (m_run > 0 && win == m_gid && m_run < MAX_BURST) m_run++;
                else m_run = 1;
                m_gid   = win;
                m_data  = req_data[win*8 +: 8];
                m_t     = 1;
                m_acked = 1'b0;
            end else if (m_t == 1) begin
                m_t = 2;
            end else if (m_t >= 2) begin
                if (m_acked) begin
                    if (!tx_busy) m_t = -1;
                end else if (tx_busy) begin
                    m_acked = 1'b1;
                end else if (m_t == ACK_TO) begin
                    m_err_next = 1'b1;
                    m_t        = -1;
                    m_run      = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Transmitter: 0 = busy frame_len cycles, 1 = never busy, 2 = busy held, 3 = random length / drop.
    initial begin
        bit saw;
        int left;
        tx_busy = 1'b0;
        left    = 0;
        forever begin
            @(negedge clk);
            saw = (tx_start === 1'b1);
            @(posedge clk);
            #1;
            case (tx_mode)
                1: begin
                    left    = 0;
                    tx_busy = 1'b0;
                end
                2: tx_busy = 1'b1;
                default: begin
                    if (saw) begin
                        if (tx_mode == 3 && $urandom_range(0, 7) == 0) left = 0;
                        else left = (tx_mode == 3) ? int'($urandom_range(1, 6)) : frame_len;
                    end
                    tx_busy = (left > 0);
                    if (left > 0) left--;
                end
            endcase
        end
    end

    // Requesters: fixed mask with per-lane byte limits, or random valid/data each cycle.
    initial begin
        logic [NREQ-1:0] took;
        req_vld  = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            took = req_rdy & req_vld;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (took[i] === 1'b1) begin
                    seq[i]++;
                    if (rem[i] > 0) rem[i]--;
                end
                if (req_mode == 1) begin
                    req_vld[i]         = ($urandom_range(0, 2) != 0);
                    req_data[i*8 +: 8] = 8'($urandom);
                end else begin
                    req_vld[i]         = vld_mask[i] && (rem[i] != 0);
                    req_data[i*8 +: 8] = base[i] + 8'(seq[i]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int limit, input int mode);
        vld_mask = mask;
        req_mode = mode;
        for (int i = 0; i < NREQ; i++) rem[i] = limit;
    endtask

    task automatic clearLogs();
        dut_grants.delete();
        dut_bytes.delete();
        start_cycles.delete();
        err_cycles.delete();
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic waitQuiet(input int budget);
        int n;
        n = 0;
        while (!(m_t < 0 && !tx_busy) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("wait_quiet", 32'(m_t < 0 && !tx_busy), 32'd1);
    endtask

    task automatic waitGrants(input int count, input int budget);
        int n;
        n = 0;
        while (dut_grants.size() < count && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("wait_grants", 32'(dut_grants.size() >= count), 32'd1);
    endtask

    function automatic int grantAt(input int k);
        return (k < dut_grants.size()) ? dut_grants[k] : -1;
    endfunction

    function automatic int byteAt(input int k);
        return (k < dut_bytes.size()) ? dut_bytes[k] : -1;
    endfunction

    initial begin
        int exp_a_g[9];
        int exp_a_b[9];
        int exp_b_g[6];
        int exp_d_g[3];
        int r0;
        int s0;
        int n;
        exp_a_g = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        exp_a_b = '{8'h80, 8'h81, 8'h90, 8'h91, 8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'h82};
        exp_b_g = '{1, 1, 3, 3, 1, 1};
        exp_d_g = '{1, 3, 1};
        total = 0;
        bad = 0;
        rdy_seen = 0;
        start_seen = 0;
        tx_mode = 0;
        frame_len = 10;
        rst = 1'b1;
        base[0] = 8'h80;
        base[1] = 8'h90;
        base[2] = 8'hA0;
        base[3] = 8'hB0;
        applyStimulus('0, -1, 0);
        clearLogs();
        tick(3);
        rst = 1'b0;

        checkOutput("reset grant_id", 32'(grant_id), 32'd3);
        checkOutput("reset tx_data", 32'(tx_data), 32'h00);
        checkOutput("reset tx_start", 32'(tx_start), 32'd0);
        checkOutput("reset ack_err", 32'(ack_err), 32'd0);
        checkOutput("reset req_rdy", 32'(req_rdy), 32'd0);

        $display("[TB] all four lanes valid, 10-cycle frames");
        applyStimulus(4'b1111, -1, 0);
        waitGrants(9, 400);
        tick(2);
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("lanes grant%0d", k), 32'(grantAt(k)), 32'(exp_a_g[k]));
            checkOutput($sformatf("lanes byte%0d", k), 32'(byteAt(k)), 32'(exp_a_b[k]));
        end

        $display("[TB] lanes 1 and 3 valid");
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        doReset();
        applyStimulus(4'b1010, -1, 0);
        waitGrants(6, 300);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("pair grant%0d", k), 32'(grantAt(k)), 32'(exp_b_g[k]));

        $display("[TB] lane 2 alone, five bytes");
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        doReset();
        applyStimulus(4'b0100, 5, 0);
        waitGrants(5, 300);
        waitQuiet(100);
        tick(20);
        checkOutput("solo grant count", 32'(dut_grants.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("solo grant%0d", k), 32'(grantAt(k)), 32'd2);
            checkOutput($sformatf("solo byte%0d", k), 32'(byteAt(k)), 32'(8'hA0 + k));
        end

        $display("[TB] transmitter never acknowledges");
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        tx_mode = 1;
        doReset();
        applyStimulus(4'b1010, -1, 0);
        waitGrants(3, 200);
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("timeout grant%0d", k), 32'(grantAt(k)), 32'(exp_d_g[k]));
        checkOutput("timeout errs", 32'(err_cycles.size() >= 2), 32'd1);
        if (err_cycles.size() > 0 && start_cycles.size() > 0)
            checkOutput("timeout latency", 32'(err_cycles[0] - start_cycles[0]), 32'(ACK_TO));
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        tx_mode = 0;

        $display("[TB] reset during a frame");
        tick(2);
        doReset();
        applyStimulus(4'b0100, -1, 0);
        n = 0;
        while (!(m_t >= 2 && m_acked) && n < 60) begin
            tick(1);
            n++;
        end
        checkOutput("reached wait_done", 32'(m_t >= 2 && m_acked), 32'd1);
        tick(2);
        doReset();
        checkOutput("midframe rst tx_data", 32'(tx_data), 32'h00);
        checkOutput("midframe rst grant_id", 32'(grant_id), 32'd3);
        checkOutput("midframe rst tx_start", 32'(tx_start), 32'd0);
        checkOutput("midframe rst req_rdy", 32'(req_rdy), 32'd0);
        waitGrants(1, 60);
        checkOutput("after rst grant", 32'(grantAt(0)), 32'd2);

        $display("[TB] transmitter held busy");
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        tx_mode = 2;
        tick(2);
        r0 = rdy_seen;
        s0 = start_seen;
        applyStimulus(4'b1111, -1, 0);
        tick(20);
        checkOutput("held busy rdy", 32'(rdy_seen - r0), 32'd0);
        checkOutput("held busy start", 32'(start_seen - s0), 32'd0);
        tx_mode = 0;
        tick(5);
        checkOutput("busy release grant", 32'(rdy_seen > r0), 32'd1);

        $display("[TB] random traffic");
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        doReset();
        tx_mode = 3;
        s0 = start_seen;
        applyStimulus('0, -1, 1);
        tick(2000);
        applyStimulus('0, -1, 0);
        waitQuiet(100);
        checkOutput("random frames seen", 32'(start_seen > s0 + 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
